// File: rtl/maxpool_2x2.sv
// maxpool_2x2: streaming 2x2 / stride-2 max-pooling stage.
// Takes row-major pixels one per accepted beat. Keeps the horizontal maxima of
// each even row in a half-width line buffer. Emits one pooled value per window
// while the odd row streams in, with valid/ready backpressure on the output.
module maxpool_2x2 #(
  parameter int DW    = 8,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          frame_done
);

  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int LBD = IMG_W / 2;
  localparam int LIW = (LBD > 1) ? $clog2(LBD) : 1;

  typedef enum logic {EVEN_ROW, ODD_ROW} state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [DW-1:0] h_reg;
  logic [DW-1:0] lbuf [LBD];

  logic           accept;
  logic           col_last;
  logic           row_last;
  logic [LIW-1:0] lidx;
  logic [DW-1:0]  hmax;
  logic [DW-1:0]  vmax;

  // A new pixel can enter whenever the output slot is empty or being drained
  // this cycle, so a held result stalls the whole input side.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  assign lidx     = LIW'(col >> 1);

  // Unsigned maxima: the horizontal pair, then that against the stored even-row pair.
  assign hmax = (in_data > h_reg) ? in_data : h_reg;
  assign vmax = (lbuf[lidx] > hmax) ? lbuf[lidx] : hmax;

  // Line buffer of even-row horizontal maxima; it is written before it is
  // read in every frame, so it carries no reset.
  always_ff @(posedge clk) begin
    if (!clear && accept && col[0] && (state == EVEN_ROW)) begin
      lbuf[lidx] <= hmax;
    end
  end

  // Position counters, row-parity FSM, the pending pixel and the output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= EVEN_ROW;
      col        <= '0;
      row        <= '0;
      h_reg      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else if (clear) begin
      state      <= EVEN_ROW;
      col        <= '0;
      row        <= '0;
      h_reg      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (col_last) begin
          col   <= '0;
          row   <= row_last ? '0 : row + 1'b1;
          state <= (state == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
        end else begin
          col <= col + 1'b1;
        end
        if (!col[0]) begin
          h_reg <= in_data;
        end else if (state == ODD_ROW) begin
          out_data   <= vmax;
          out_valid  <= 1'b1;
          frame_done <= row_last && col_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool_2x2.sv
// tb_maxpool_2x2: directed bench for the 2x2 max-pooling stage.
// A 4x4 instance covers the streaming, stall, unsigned, back-to-back and abort
// scenarios. A default 8x8 instance runs a random stream against a reference model.
module tb_maxpool_2x2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst   = 1'b0;
  logic clear = 1'b0;

  logic       in_valid4 = 1'b0;
  logic [7:0] in_data4  = '0;
  logic       in_ready4;
  logic       out_valid4;
  logic [7:0] out_data4;
  logic       out_ready4 = 1'b1;
  logic       frame_done4;

  logic       in_valid8 = 1'b0;
  logic [7:0] in_data8  = '0;
  logic       in_ready8;
  logic       out_valid8;
  logic [7:0] out_data8;
  logic       out_ready8 = 1'b1;
  logic       frame_done8;

  int checks = 0;
  int errors = 0;

  logic [7:0] q4 [$];
  logic [7:0] q8 [$];
  int fd4 = 0;
  int fd8 = 0;

  maxpool_2x2 #(.DW(8), .IMG_W(4), .IMG_H(4)) dut4 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid4), .in_data(in_data4), .in_ready(in_ready4),
    .out_valid(out_valid4), .out_data(out_data4), .out_ready(out_ready4),
    .frame_done(frame_done4)
  );

  maxpool_2x2 dut8 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid8), .in_data(in_data8), .in_ready(in_ready8),
    .out_valid(out_valid8), .out_data(out_data8), .out_ready(out_ready8),
    .frame_done(frame_done8)
  );

  // Record every output handshake that the next rising edge will complete, and count frame_done pulses.
  always @(negedge clk) begin
    if (out_valid4 && out_ready4) q4.push_back(out_data4);
    if (out_valid8 && out_ready8) q8.push_back(out_data8);
    if (frame_done4) fd4++;
    if (frame_done8) fd8++;
  end

  task automatic pulse_reset();
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Offer one pixel to the 4x4 instance and return #1 after the edge that accepts it.
  task automatic applyStimulus(input logic [7:0] v);
    int n;
    n = 0;
    in_valid4 = 1'b1;
    in_data4  = v;
    #1;
    while (!in_ready4 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("[TB] FAIL push_timeout pixel=%0d in_ready stayed 0, required 1", v);
    end
    @(posedge clk); #1;
    in_valid4 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    checks++;
    if (out_valid4 !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %0b exp 0", out_valid4); end
    checks++;
    if (out_data4 !== 8'd0) begin errors++; $display("[TB] FAIL reset_out_data got %0d exp 0", out_data4); end
    checks++;
    if (frame_done4 !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done got %0b exp 0", frame_done4); end
    checks++;
    if (in_ready4 !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %0b exp 1", in_ready4); end
    checks++;
    if (in_ready8 !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready8 got %0b exp 1", in_ready8); end
    #5 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    logic vld;
    out_ready4 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(8'(i));
      vld = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      checks++;
      if (out_valid4 !== vld) begin errors++; $display("[TB] FAIL stream_valid pixel=%0d got %0b exp %0b", i, out_valid4, vld); end
      if (vld) begin
        checks++;
        if (out_data4 !== 8'(i)) begin errors++; $display("[TB] FAIL stream_data pixel=%0d got %0d exp %0d", i, out_data4, i); end
      end
      checks++;
      if (frame_done4 !== (i == 15)) begin errors++; $display("[TB] FAIL stream_frame_done pixel=%0d got %0b exp %0b", i, frame_done4, (i == 15)); end
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp [4];
    exp = '{8'd5, 8'd7, 8'd13, 8'd15};
    pulse_reset();
    q4.delete();
    out_ready4 = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(8'(i));
    out_ready4 = 1'b0;
    applyStimulus(8'd5);
    checks++;
    if (out_valid4 !== 1'b1 || out_data4 !== 8'd5) begin
      errors++; $display("[TB] FAIL stall_first valid=%0b data=%0d exp valid=1 data=5", out_valid4, out_data4);
    end
    in_valid4 = 1'b1;
    in_data4  = 8'd6;
    repeat (5) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready4 !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready got %0b exp 0", in_ready4); end
      checks++;
      if (out_data4 !== 8'd5 || out_valid4 !== 1'b1) begin
        errors++; $display("[TB] FAIL stall_hold valid=%0b data=%0d exp valid=1 data=5", out_valid4, out_data4);
      end
    end
    out_ready4 = 1'b1;
    for (int i = 6; i < 16; i++) applyStimulus(8'(i));
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q4.size() != 4) begin
      errors++; $display("[TB] FAIL stall_count got %0d exp 4", q4.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q4[i] !== exp[i]) begin errors++; $display("[TB] FAIL stall_seq idx=%0d got %0d exp %0d", i, q4[i], exp[i]); end
      end
    end
  endtask

  task automatic test_unsigned_ties();
    logic [7:0] pix [16];
    logic [7:0] exp [4];
    pix = '{8'd255, 8'd0,   8'd9,   8'd9,
            8'd0,   8'd255, 8'd9,   8'd9,
            8'd128, 8'd200, 8'd130, 8'd129,
            8'd199, 8'd129, 8'd131, 8'd130};
    exp = '{8'd255, 8'd9, 8'd200, 8'd131};
    pulse_reset();
    q4.delete();
    out_ready4 = 1'b1;
    for (int i = 0; i < 16; i++) applyStimulus(pix[i]);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q4.size() != 4) begin
      errors++; $display("[TB] FAIL unsigned_count got %0d exp 4", q4.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q4[i] !== exp[i]) begin errors++; $display("[TB] FAIL unsigned_val idx=%0d got %0d exp %0d", i, q4[i], exp[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [8];
    exp = '{8'd5, 8'd7, 8'd13, 8'd15, 8'd15, 8'd13, 8'd7, 8'd5};
    pulse_reset();
    q4.delete();
    fd4 = 0;
    out_ready4 = 1'b1;
    for (int i = 0; i < 16; i++) applyStimulus(8'(i));
    for (int i = 0; i < 16; i++) applyStimulus(8'(15 - i));
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (fd4 != 2) begin errors++; $display("[TB] FAIL b2b_frame_done got %0d pulses exp 2", fd4); end
    checks++;
    if (q4.size() != 8) begin
      errors++; $display("[TB] FAIL b2b_count got %0d exp 8", q4.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (q4[i] !== exp[i]) begin errors++; $display("[TB] FAIL b2b_val idx=%0d got %0d exp %0d", i, q4[i], exp[i]); end
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] exp [4];
    logic [7:0] res_a [$];
    exp = '{8'd105, 8'd107, 8'd113, 8'd115};
    pulse_reset();
    out_ready4 = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(8'(i));
    #2 rst = 1'b0;
    #1;
    checks++;
    if (out_valid4 !== 1'b0 || out_data4 !== 8'd0 || in_ready4 !== 1'b1 || frame_done4 !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_rst_outputs valid=%0b data=%0d ready=%0b done=%0b exp 0 0 1 0",
                         out_valid4, out_data4, in_ready4, frame_done4);
    end
    #3 rst = 1'b1;
    @(posedge clk); #1;
    q4.delete();
    for (int i = 0; i < 16; i++) applyStimulus(8'(100 + i));
    repeat (2) @(posedge clk);
    #1;
    res_a = q4;
    checks++;
    if (res_a.size() != 4) begin
      errors++; $display("[TB] FAIL abort_rst_count got %0d exp 4", res_a.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (res_a[i] !== exp[i]) begin errors++; $display("[TB] FAIL abort_rst_val idx=%0d got %0d exp %0d", i, res_a[i], exp[i]); end
      end
    end

    for (int i = 0; i < 6; i++) applyStimulus(8'(i));
    clear     = 1'b1;
    in_valid4 = 1'b1;
    in_data4  = 8'd250;
    @(posedge clk); #1;
    clear     = 1'b0;
    in_valid4 = 1'b0;
    checks++;
    if (out_valid4 !== 1'b0 || out_data4 !== 8'd0 || frame_done4 !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_clr_outputs valid=%0b data=%0d done=%0b exp 0 0 0", out_valid4, out_data4, frame_done4);
    end
    q4.delete();
    for (int i = 0; i < 16; i++) applyStimulus(8'(100 + i));
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q4.size() != res_a.size()) begin
      errors++; $display("[TB] FAIL abort_clr_count got %0d exp %0d", q4.size(), res_a.size());
    end else begin
      for (int i = 0; i < q4.size(); i++) begin
        checks++;
        if (q4[i] !== exp[i]) begin errors++; $display("[TB] FAIL abort_clr_val idx=%0d got %0d exp %0d", i, q4[i], exp[i]); end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] pix [64];
    logic [7:0] exp [16];
    logic [7:0] m;
    logic [7:0] prev_data;
    logic       acc;
    logic       prev_stall;
    int k;
    int cyc;
    for (int i = 0; i < 64; i++) pix[i] = 8'($urandom_range(0, 255));
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        m = pix[(2*r)*8 + 2*c];
        if (pix[(2*r)*8 + 2*c + 1] > m) m = pix[(2*r)*8 + 2*c + 1];
        if (pix[(2*r+1)*8 + 2*c] > m) m = pix[(2*r+1)*8 + 2*c];
        if (pix[(2*r+1)*8 + 2*c + 1] > m) m = pix[(2*r+1)*8 + 2*c + 1];
        exp[r*4 + c] = m;
      end
    end
    q8.delete();
    fd8 = 0;
    k = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    while (k < 64 && cyc < 3000) begin
      if (prev_stall) begin
        checks++;
        if (out_data8 !== prev_data) begin errors++; $display("[TB] FAIL random_hold got %0d exp %0d", out_data8, prev_data); end
      end
      out_ready8 = ($urandom_range(0, 3) != 0);
      in_valid8  = 1'b1;
      in_data8   = pix[k];
      #1;
      acc        = in_ready8;
      prev_stall = out_valid8 && !out_ready8;
      prev_data  = out_data8;
      @(posedge clk); #1;
      cyc++;
      if (acc) k++;
    end
    in_valid8  = 1'b0;
    out_ready8 = 1'b1;
    cyc = 0;
    while (q8.size() < 16 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (fd8 != 1) begin errors++; $display("[TB] FAIL random_frame_done got %0d pulses exp 1", fd8); end
    checks++;
    if (q8.size() != 16) begin
      errors++; $display("[TB] FAIL random_count got %0d exp 16", q8.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (q8[i] !== exp[i]) begin errors++; $display("[TB] FAIL random_val idx=%0d got %0d exp %0d", i, q8[i], exp[i]); end
      end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    $display("[TB] starting maxpool_2x2 bench");
    test_reset();
    test_stream();
    test_stall();
    test_unsigned_ties();
    test_back_to_back();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
